// File: rtl/landing_judge_pkg.sv
// Shared constants, state encoding and helpers for the landing judge.
// Classifies bottle landings and keeps score for the display and LED stages.
package landing_judge_pkg;

  localparam int X_W         = 10;
  localparam int OFF_W       = X_W + 1;
  localparam int SCORE_W     = 14;
  localparam int COMBO_W     = 4;
  localparam int PERFECT_TOL = 4;
  localparam int MAX_COMBO   = 8;
  localparam int SCORE_MAX   = 9999;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_CALC     = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_DEAD     = 2'd3
  } judge_state_e;

  // Pick the subtraction direction by magnitude so the result never wraps.
  function automatic logic [OFF_W-1:0] abs_diff(input logic [X_W-1:0] a,
                                                input logic [X_W-1:0] b);
    logic [OFF_W-1:0] r;
    if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, b} - {1'b0, a};
    end
    return r;
  endfunction

endpackage

// File: rtl/landing_judge_if.sv
// Landing event bus from the flight logic plus the judged results
// presented to the LED and display stages.
interface landing_judge_if;
  import landing_judge_pkg::*;

  logic               land_valid;
  logic [X_W-1:0]     land_x;
  logic [X_W-1:0]     plat_x;
  logic [X_W-1:0]     plat_half;
  logic               perfect;
  logic               dead;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [SCORE_W-1:0] best;
  logic               busy;

  modport master (
    output land_valid, land_x, plat_x, plat_half,
    input  perfect, dead, score, combo, best, busy
  );

  modport slave (
    input  land_valid, land_x, plat_x, plat_half,
    output perfect, dead, score, combo, best, busy
  );

endinterface

// File: rtl/landing_judge_sat_add14.sv
// 14-bit adder that clips its result at the 4-digit display limit.
module landing_judge_sat_add14
  import landing_judge_pkg::*;
(
  input  logic [SCORE_W-1:0] i_a,
  input  logic [SCORE_W-1:0] i_b,
  output logic [SCORE_W-1:0] o_sum
);

  localparam logic [SCORE_W:0]   SAT_LIM_W = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] SAT_LIM   = SCORE_W'(SCORE_MAX);

  logic [SCORE_W:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b};

  // Clip the one-bit-wider raw sum at the display limit.
  always_comb begin
    if (w_raw > SAT_LIM_W) begin
      o_sum = SAT_LIM;
    end else begin
      o_sum = w_raw[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/landing_judge.sv
// Landing judge: captures a landing, measures the offset from the platform
// centre, and classifies it as perfect, normal or a miss.
module landing_judge
  import landing_judge_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_restart,
  landing_judge_if.slave  bus
);

  localparam logic [OFF_W-1:0]   TOL_OFF   = OFF_W'(PERFECT_TOL);
  localparam logic [COMBO_W-1:0] COMBO_SAT = COMBO_W'(MAX_COMBO);

  judge_state_e       r_state, w_state_nxt;
  logic [X_W-1:0]     r_land_x, w_land_x_nxt;
  logic [X_W-1:0]     r_plat_x, w_plat_x_nxt;
  logic [X_W-1:0]     r_plat_half, w_plat_half_nxt;
  logic [OFF_W-1:0]   r_off, w_off_nxt;
  logic               r_perfect, w_perfect_nxt;
  logic               r_dead, w_dead_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [COMBO_W-1:0] r_combo, w_combo_nxt;
  logic [SCORE_W-1:0] r_best, w_best_nxt;
  logic               r_busy, w_busy_nxt;

  logic [OFF_W-1:0]   w_off_calc;
  logic [OFF_W-1:0]   w_half_ext;
  logic               w_calc_perfect;
  logic               w_calc_miss;
  logic               w_is_perfect;
  logic               w_is_normal;
  logic [COMBO_W-1:0] w_combo_inc;
  logic [SCORE_W-1:0] w_add_b;
  logic [SCORE_W-1:0] w_score_sum;
  logic [SCORE_W-1:0] w_best_max;

  assign w_off_calc = abs_diff(r_land_x, r_plat_x);
  assign w_half_ext = {1'b0, r_plat_half};

  // perfect and dead are decided a cycle early so both are registered and
  // visible during the CLASSIFY cycle; score and combo follow a cycle later.
  assign w_calc_perfect = (w_off_calc <= TOL_OFF);
  assign w_calc_miss    = !w_calc_perfect && (w_off_calc > w_half_ext);

  assign w_is_perfect = (r_off <= TOL_OFF);
  assign w_is_normal  = !w_is_perfect && (r_off <= w_half_ext);

  assign w_combo_inc = (r_combo >= COMBO_SAT) ? COMBO_SAT : (r_combo + 4'd1);
  assign w_add_b     = w_is_perfect ? {{(SCORE_W-COMBO_W-1){1'b0}}, w_combo_inc, 1'b0}
                                    : SCORE_W'(1);
  assign w_best_max  = (r_score > r_best) ? r_score : r_best;

  landing_judge_sat_add14 u_sat_add14 (
    .i_a   (r_score),
    .i_b   (w_add_b),
    .o_sum (w_score_sum)
  );

  // Next-state and next-output logic; restart overrides everything but best.
  always_comb begin
    w_state_nxt     = r_state;
    w_land_x_nxt    = r_land_x;
    w_plat_x_nxt    = r_plat_x;
    w_plat_half_nxt = r_plat_half;
    w_off_nxt       = r_off;
    w_perfect_nxt   = 1'b0;
    w_dead_nxt      = r_dead;
    w_score_nxt     = r_score;
    w_combo_nxt     = r_combo;
    w_best_nxt      = r_best;
    w_busy_nxt      = r_busy;

    if (i_restart) begin
      w_state_nxt = ST_PLAY;
      w_dead_nxt  = 1'b0;
      w_score_nxt = '0;
      w_combo_nxt = '0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (bus.land_valid) begin
            w_land_x_nxt    = bus.land_x;
            w_plat_x_nxt    = bus.plat_x;
            w_plat_half_nxt = bus.plat_half;
            w_busy_nxt      = 1'b1;
            w_state_nxt     = ST_CALC;
          end else begin
            w_state_nxt = ST_PLAY;
          end
        end
        ST_CALC: begin
          w_off_nxt     = w_off_calc;
          w_perfect_nxt = w_calc_perfect;
          w_dead_nxt    = w_calc_miss;
          w_state_nxt   = ST_CLASSIFY;
        end
        ST_CLASSIFY: begin
          w_busy_nxt = 1'b0;
          if (w_is_perfect) begin
            w_combo_nxt = w_combo_inc;
            w_score_nxt = w_score_sum;
            w_state_nxt = ST_PLAY;
          end else if (w_is_normal) begin
            w_combo_nxt = '0;
            w_score_nxt = w_score_sum;
            w_state_nxt = ST_PLAY;
          end else begin
            w_combo_nxt = '0;
            w_dead_nxt  = 1'b1;
            w_best_nxt  = w_best_max;
            w_state_nxt = ST_DEAD;
          end
        end
        ST_DEAD: begin
          w_dead_nxt  = 1'b1;
          w_state_nxt = ST_DEAD;
        end
        default: begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_PLAY;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_PLAY;
      r_land_x    <= '0;
      r_plat_x    <= '0;
      r_plat_half <= '0;
      r_off       <= '0;
      r_perfect   <= 1'b0;
      r_dead      <= 1'b0;
      r_score     <= '0;
      r_combo     <= '0;
      r_best      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_land_x    <= w_land_x_nxt;
      r_plat_x    <= w_plat_x_nxt;
      r_plat_half <= w_plat_half_nxt;
      r_off       <= w_off_nxt;
      r_perfect   <= w_perfect_nxt;
      r_dead      <= w_dead_nxt;
      r_score     <= w_score_nxt;
      r_combo     <= w_combo_nxt;
      r_best      <= w_best_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.perfect = r_perfect;
  assign bus.dead    = r_dead;
  assign bus.score   = r_score;
  assign bus.combo   = r_combo;
  assign bus.best    = r_best;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_landing_judge.sv
// Scoreboard bench for landing_judge: the driver queues the expected result of
// each judged landing, and a monitor checks it when busy falls.
module tb_landing_judge;
  import landing_judge_pkg::*;

  typedef struct {
    logic perfect;
    logic dead;
    int   score;
    int   combo;
    int   best;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic restart = 1'b0;

  landing_judge_if bus();

  landing_judge dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_restart (restart),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_score = 0;
  int   m_combo = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic p, input logic d, input int s, input int c, input int b);
    exp_t e;
    e.perfect = p;
    e.dead    = d;
    e.score   = s;
    e.combo   = c;
    e.best    = b;
    exp_q.push_back(e);
  endtask

  // One land_valid pulse, then idle so landings are 5 cycles apart.
  task automatic land(input int x);
    @(negedge clk);
    bus.land_valid = 1'b1;
    bus.land_x     = 10'(x);
    @(negedge clk);
    bus.land_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic land_exp(input int x, input logic p, input logic d,
                          input int s, input int c, input int b);
    push(p, d, s, c, b);
    land(x);
  endtask

  // Perfect/normal landings against plat_x=300, plat_half=20 with best fixed.
  task automatic model_land(input int x, input int best_v);
    int off;
    off = (x > 300) ? (x - 300) : (300 - x);
    if (off <= PERFECT_TOL) begin
      m_combo = (m_combo + 1 > MAX_COMBO) ? MAX_COMBO : m_combo + 1;
      m_score = (m_score + 2 * m_combo > SCORE_MAX) ? SCORE_MAX : m_score + 2 * m_combo;
      push(1'b1, 1'b0, m_score, m_combo, best_v);
    end else begin
      m_combo = 0;
      m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
      push(1'b0, 1'b0, m_score, m_combo, best_v);
    end
    land(x);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Monitor: tracks the busy window and compares once it closes.
  initial begin
    int   bcnt = 0;
    int   pother = 0;
    logic prev_busy = 1'b0;
    logic p2 = 1'b0;
    logic d2 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        bcnt = 0; pother = 0; p2 = 1'b0; d2 = 1'b0;
      end else begin
        if (bus.busy) begin
          bcnt++;
          if (bcnt == 2) begin
            p2 = bus.perfect;
            d2 = bus.dead;
          end else if (bus.perfect) begin
            pother++;
          end
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_judgement actual=1 required=0 at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("perfect_at_T2", p2, e.perfect);
            chk("stray_perfect", pother, 0);
            chk("dead_at_T2", d2, e.dead);
            chk("dead", bus.dead, e.dead);
            chk("score", bus.score, e.score);
            chk("combo", bus.combo, e.combo);
            chk("best", bus.best, e.best);
            chk("perfect_after", bus.perfect, 0);
          end
          bcnt = 0; pother = 0; p2 = 1'b0; d2 = 1'b0;
        end else begin
          chk("idle_perfect", bus.perfect, 0);
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    bus.land_valid = 1'b0;
    bus.land_x     = 10'd0;
    bus.plat_x     = 10'd300;
    bus.plat_half  = 10'd20;
    repeat (2) @(negedge clk);
    chk("rst_perfect", bus.perfect, 0);
    chk("rst_dead", bus.dead, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_combo", bus.combo, 0);
    chk("rst_best", bus.best, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    land_exp(302, 1'b1, 1'b0, 2, 1, 0);
    land_exp(302, 1'b1, 1'b0, 6, 2, 0);
    land_exp(302, 1'b1, 1'b0, 12, 3, 0);
    land_exp(315, 1'b0, 1'b0, 13, 0, 0);
    land_exp(330, 1'b0, 1'b1, 13, 0, 13);

    for (int i = 0; i < 3; i++) land(302);
    chk("dead_hold", bus.dead, 1);
    chk("dead_score", bus.score, 13);
    chk("dead_busy", bus.busy, 0);

    pulse_restart();
    chk("rs_dead", bus.dead, 0);
    chk("rs_score", bus.score, 0);
    chk("rs_combo", bus.combo, 0);
    chk("rs_best", bus.best, 13);
    chk("rs_busy", bus.busy, 0);

    @(negedge clk);
    restart        = 1'b1;
    bus.land_valid = 1'b1;
    bus.land_x     = 10'd302;
    @(negedge clk);
    restart        = 1'b0;
    bus.land_valid = 1'b0;
    chk("simul_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("simul_busy_late", bus.busy, 0);
    chk("simul_score", bus.score, 0);

    push(1'b1, 1'b0, 2, 1, 13);
    @(negedge clk);
    bus.land_valid = 1'b1;
    bus.land_x     = 10'd302;
    @(negedge clk);
    chk("calc_busy", bus.busy, 1);
    @(negedge clk);
    bus.land_valid = 1'b0;
    repeat (3) @(negedge clk);

    pulse_restart();
    m_score = 0;
    m_combo = 0;
    for (int i = 0; i < 19; i++) model_land(315, 13);
    for (int i = 0; i < 627; i++) model_land(302, 13);
    chk("presat_score", bus.score, 9995);
    chk("presat_combo", bus.combo, 8);
    model_land(302, 13);
    chk("sat_score", bus.score, 9999);
    chk("sat_combo", bus.combo, 8);

    @(negedge clk);
    bus.land_valid = 1'b1;
    bus.land_x     = 10'd302;
    @(negedge clk);
    bus.land_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_perfect", bus.perfect, 0);
    chk("arst_dead", bus.dead, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_combo", bus.combo, 0);
    chk("arst_best", bus.best, 0);
    chk("arst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_best", bus.best, 0);
    chk("post_rst_score", bus.score, 0);

    chk("pending_expect", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/landing_judge.md
Name: landing_judge

Overview:
- Scoring stage that sits directly upstream of the LED blink block. It consumes each landing event from the physics/flight logic and classifies it as perfect, normal or dead.
- Drives the one-cycle `perfect` pulse and the level `dead` signal that the LED block consumes.
- Maintains the running score, the perfect-combo streak and the session best score for the display stage.

Parameters:
- X_W, 10, width of horizontal positions (pixels).
- PERFECT_TOL, 4, max |land_x - plat_x| that counts as perfect.
- MAX_COMBO, 8, combo streak saturation value.
- SCORE_MAX, 9999, score saturation value (4-digit display).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous start-new-game request (debounced, single-cycle).
- land_valid  in  1  single-cycle strobe: bottle has landed, land_x is valid.
- land_x  in  X_W  landing x of bottle centre.
- plat_x  in  X_W  target platform centre x, sampled with land_valid.
- plat_half  in  X_W  target platform half-width, sampled with land_valid.
- perfect  out  1  one-cycle pulse on a perfect landing.
- dead  out  1  level; high from a miss until restart.
- score  out  14  current game score.
- combo  out  4  current consecutive-perfect count.
- best  out  14  best score this power-on session.
- busy  out  1  high while a landing is being judged.

Behaviour:
- Reset (rst_n low, async): state=PLAY; perfect=0, dead=0, score=0, combo=0, best=0, busy=0; capture regs cleared.
- States: PLAY, CALC, CLASSIFY, DEAD.
- PLAY: land_valid=1 captures land_x, plat_x and plat_half into registers; next state CALC; busy=1.
- CALC: off = |land_x_q - plat_x_q|.
  - Computed in X_W+1 bits to avoid wrap; the subtraction direction is chosen by comparison, never two's-complement overflow.
  - Next state CLASSIFY.
- CLASSIFY: evaluate the registered off, in priority order:
  - off <= PERFECT_TOL: perfect=1 for exactly this cycle. combo_n = min(combo+1, MAX_COMBO). score += 2*combo_n. combo = combo_n. Next PLAY.
  - else off <= plat_half: normal landing. combo=0; score += 1; next PLAY.
  - else: miss. dead=1; combo=0; score unchanged; best = max(best, score); next DEAD.
  - busy drops when the state returns to PLAY or enters DEAD.
- Latency: perfect asserts exactly 2 cycles after the land_valid cycle (land_valid @T -> CALC @T+1 -> perfect high @T+2).
- Score addition saturates at SCORE_MAX; never wraps.
- PERFECT_TOL > plat_half: a perfect classification still wins. Perfect is checked first.
- plat_half=0 with off=0: perfect, when PERFECT_TOL >= 0.
- DEAD: dead held high; land_valid ignored; perfect stays 0.
- restart (any state): next cycle state=PLAY, dead=0, score=0, combo=0, busy=0, perfect=0; best retained.
  - An in-flight judgement is discarded.
  - restart takes priority over land_valid in the same cycle; that landing is dropped.
- land_valid while busy (CALC/CLASSIFY): ignored. No queueing.
- Async reset mid-judgement: all outputs return to reset values immediately; no perfect pulse is emitted.
- best is compared only on entry to DEAD; a game still running never updates best.

Decomposition:
- Shared constants in the consts include alongside the blink constants: PERFECT_TOL, MAX_COMBO, SCORE_MAX and the state encodings (2-bit, PLAY=0, CALC=1, CLASSIFY=2, DEAD=3).
- One natural sub-module: sat_add14. 14-bit saturating adder (a + b clipped to SCORE_MAX), used for the score update.
- All other logic is flat in landing_judge.

Test Plan:
- Perfect streak:
  - Stimulus: reset; plat_x=300, plat_half=20; land_x=302 three times, spaced 5 cycles.
  - Required: perfect pulses exactly at T+2 each time.
  - Required: combo 1,2,3; score 2,6,12; dead=0.
- Normal breaks combo:
  - Stimulus: after the above, land_x=315.
  - Required: no perfect pulse; combo=0; score=13.
- Miss and restart:
  - Stimulus: land_x=330 (off=30>20).
  - Required: dead=1 at T+2; score=13; best=13.
  - Stimulus: further land_valid pulses.
  - Required: ignored.
  - Stimulus: restart.
  - Required: dead=0, score=0, combo=0, best=13.
- Saturation:
  - Stimulus: preload to score=9995, combo=MAX_COMBO; perfect landing.
  - Required: combo stays 8; score=9999, not 10011.
- Simultaneous and busy:
  - Stimulus: restart and land_valid same cycle.
  - Required: no judgement, busy=0.
  - Stimulus: land_valid during CALC.
  - Required: ignored; only one perfect pulse.
- Async reset mid-judgement:
  - Stimulus: assert rst_n=0 in CALC.
  - Required: perfect never pulses; all outputs 0 immediately (not clock-aligned).
  - Required: best=0 after reset.
